fifo_wr_arbiter: RTL and testbench

- Shares the single write port of the team's async FIFO (asyfifo, WIDTH=8, DEPTH=16) between N write requesters in the wr_clk domain.
- Grants are round-robin and burst-based. A granted requester streams beats until it marks one as last, or until MAX_BURST beats are written.
- Throttles on the FIFO's full flag and drives the FIFO's wr_en and w_data directly.
- Captures the FIFO's wr_err as a sticky error flag.

---
 rtl/fifo_ctrl_pkg.sv | 19 +
 rtl/rr_pick.sv | 31 +++
 rtl/fifo_wr_arbiter.sv | 116 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 488 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the async-FIFO control blocks: arbiter states, FIFO geometry
// and a constant-evaluable clog2 used to size index ports.
package fifo_ctrl_pkg;

  typedef enum logic [0:0] {ST_IDLE, ST_BURST} state_e;

  localparam int unsigned FifoWidth = 8;
  localparam int unsigned FifoDepth = 16;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req scanning from rr_ptr upward,
// wrapping modulo N.
module rr_pick
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] rr_ptr,
  output logic           found,
  output logic [IDW-1:0] idx
);

  int             c;
  logic [IDW-1:0] cand;

  // Scan from the far end so the candidate closest to rr_ptr is written last and wins.
  always_comb begin
    found = |req;
    idx   = '0;
    c     = 0;
    cand  = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      c    = (int'(rr_ptr) + i) % int'(N);
      cand = IDW'(c);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-based sharing of the async FIFO write port between N requesters,
// throttled by fifo_full, with a sticky capture of the FIFO write-error pulse.
module fifo_wr_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter int unsigned WIDTH     = FifoWidth,
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned IDW       = clog2(N)
) (
  input  logic               wr_clk,
  input  logic               rst,
  input  logic [N-1:0]       req_valid,
  input  logic [N*WIDTH-1:0] req_data,
  input  logic [N-1:0]       req_last,
  output logic [N-1:0]       req_ready,
  input  logic               fifo_full,
  input  logic               fifo_wr_err,
  output logic               fifo_wr_en,
  output logic [WIDTH-1:0]   fifo_w_data,
  output logic [IDW-1:0]     grant_id,
  output logic               busy,
  output logic               burst_trunc,
  output logic               err_sticky,
  input  logic               err_clr
);

  state_e         state_q;
  logic [IDW-1:0] rr_ptr_q;
  logic [7:0]     beat_cnt_q;

  logic           pick_found;
  logic [IDW-1:0] pick_idx;
  logic           in_burst;
  logic           accept;
  logic           at_max;
  logic           burst_end;
  logic [IDW-1:0] next_ptr;
  logic [WIDTH-1:0] grant_data;

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr_q),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (grant_id == IDW'(i)) grant_data = req_data[i*WIDTH +: WIDTH];
    end
  end

  // Gating with rst keeps a reset cycle from writing a beat of the abandoned burst.
  assign in_burst = (state_q == ST_BURST) & ~rst;

  always_comb begin
    req_ready = '0;
    if (in_burst & ~fifo_full) req_ready[grant_id] = 1'b1;
  end

  assign accept      = in_burst & ~fifo_full & req_valid[grant_id];
  assign fifo_wr_en  = accept;
  assign fifo_w_data = accept ? grant_data : '0;
  assign at_max      = ({1'b0, beat_cnt_q} + 9'd1) == 9'(MAX_BURST);
  assign burst_end   = req_last[grant_id] | at_max;
  assign next_ptr    = (grant_id == IDW'(N - 1)) ? '0 : grant_id + 1'b1;

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      grant_id    <= '0;
      busy        <= 1'b0;
      burst_trunc <= 1'b0;
      err_sticky  <= 1'b0;
    end else begin
      burst_trunc <= 1'b0;
      if (fifo_wr_err) begin
        err_sticky <= 1'b1;
      end else if (err_clr) begin
        err_sticky <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (pick_found) begin
            grant_id   <= pick_idx;
            busy       <= 1'b1;
            beat_cnt_q <= '0;
            state_q    <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (accept) begin
            if (burst_end) begin
              state_q     <= ST_IDLE;
              busy        <= 1'b0;
              rr_ptr_q    <= next_ptr;
              beat_cnt_q  <= '0;
              burst_trunc <= ~req_last[grant_id];
            end else begin
              beat_cnt_q <= beat_cnt_q + 8'd1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus randomized bursts
// compared against a queue-level model of the round-robin burst rules.
module tb_fifo_wr_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int MB  = 8;
  localparam int IDW = 2;

  logic           wr_clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           fifo_full;
  logic           fifo_wr_err;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_w_data;
  logic [IDW-1:0] grant_id;
  logic           busy;
  logic           burst_trunc;
  logic           err_sticky;
  logic           err_clr;

  fifo_wr_arbiter #(
    .N         (N),
    .WIDTH     (W),
    .MAX_BURST (MB),
    .IDW       (IDW)
  ) dut (
    .wr_clk      (wr_clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .fifo_full   (fifo_full),
    .fifo_wr_err (fifo_wr_err),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_w_data (fifo_w_data),
    .grant_id    (grant_id),
    .busy        (busy),
    .burst_trunc (burst_trunc),
    .err_sticky  (err_sticky),
    .err_clr     (err_clr)
  );

  always #5 wr_clk = ~wr_clk;

  int vectors = 0;
  int miscompares = 0;

  // Per-requester beat streams: {last, data}. rq drives the DUT, mq feeds the model.
  logic [8:0] rq [N][$];
  logic [8:0] mq [N][$];
  logic [7:0] got_data [$];
  logic [7:0] exp_data [$];
  int         got_grant [$];
  int         exp_grant [$];
  int         trunc_cnt, exp_trunc, stall_bad, proto_bad, first_wr, last_wr;
  bit         timed_out;

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid   = '0;
    req_data    = '0;
    req_last    = '0;
    fifo_full   = 1'b0;
    fifo_wr_err = 1'b0;
    err_clr     = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    for (int i = 0; i < N; i++) rq[i].delete();
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic drive_heads(input bit full);
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0) begin
        req_valid[i]        = 1'b1;
        req_last[i]         = rq[i][0][8];
        req_data[i*W +: W]  = rq[i][0][7:0];
      end else begin
        req_valid[i]        = 1'b0;
        req_last[i]         = 1'b0;
        req_data[i*W +: W]  = '0;
      end
    end
    fifo_full = full;
  endtask

  function automatic bit any_pending();
    for (int i = 0; i < N; i++) if (rq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit full_at(input int mode, input int start, input int cyc);
    if (mode == 1) return ($urandom_range(0, 99) < 30);
    if (mode == 2) return (cyc >= start && cyc < start + 5);
    return 1'b0;
  endfunction

  task automatic push_burst(input int r, input int len, input bit with_last);
    for (int k = 0; k < len; k++) begin
      rq[r].push_back({(with_last && k == len - 1), 8'($urandom_range(0, 255))});
    end
  endtask

  // Reference: grants go round-robin over requesters with pending beats; a grant takes
  // beats until one is last or MB beats have gone; an unfinished burst keeps the port.
  task automatic model_expect();
    int ptr, g, n;
    bit done;
    logic [8:0] e;
    for (int i = 0; i < N; i++) mq[i] = rq[i];
    exp_data.delete();
    exp_grant.delete();
    exp_trunc = 0;
    ptr = 0;
    forever begin
      g = -1;
      for (int k = N - 1; k >= 0; k--) if (mq[(ptr + k) % N].size() > 0) g = (ptr + k) % N;
      if (g < 0) break;
      exp_grant.push_back(g);
      n = 0;
      done = 1'b0;
      while (!done && mq[g].size() > 0) begin
        e = mq[g].pop_front();
        exp_data.push_back(e[7:0]);
        n++;
        if (e[8]) done = 1'b1;
        else if (n == MB) begin
          done = 1'b1;
          exp_trunc++;
        end
      end
      if (!done) break;
      ptr = (g + 1) % N;
    end
  endtask

  // Plays the queued streams into the DUT and records what it does.
  task automatic run_engine(input int full_mode, input int win_start);
    int cyc, acc;
    bit prev_busy;
    got_data.delete();
    got_grant.delete();
    trunc_cnt = 0; stall_bad = 0; proto_bad = 0; first_wr = -1; last_wr = -1;
    cyc = 0;
    prev_busy = 1'b0;
    drive_heads(full_at(full_mode, win_start, 0));
    while (any_pending() && cyc < 4000) begin
      @(negedge wr_clk);
      if (busy && !prev_busy) got_grant.push_back(int'(grant_id));
      prev_busy = busy;
      if (burst_trunc) trunc_cnt++;
      if (fifo_full && (req_ready != '0 || fifo_wr_en)) stall_bad++;
      if (req_ready != '0 && (!busy || req_ready != (4'd1 << grant_id))) proto_bad++;
      acc = -1;
      for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) acc = i;
      if ((acc >= 0) != fifo_wr_en) proto_bad++;
      if (fifo_wr_en) begin
        got_data.push_back(fifo_w_data);
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
      end
      tick();
      if (acc >= 0) void'(rq[acc].pop_front());
      cyc++;
      drive_heads(any_pending() ? full_at(full_mode, win_start, cyc) : 1'b0);
    end
    timed_out = (cyc >= 4000);
    repeat (2) begin
      @(negedge wr_clk);
      if (burst_trunc) trunc_cnt++;
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    @(negedge wr_clk);
    vectors++;
    if ({req_ready, fifo_wr_en, fifo_w_data, grant_id, busy, burst_trunc, err_sticky} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: outputs=%h required 0",
               {req_ready, fifo_wr_en, fifo_w_data, grant_id, busy, burst_trunc, err_sticky});
    end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge wr_clk);
      vectors++;
      if ({req_ready, fifo_wr_en, fifo_w_data, grant_id, busy, burst_trunc, err_sticky} !== '0)
      begin
        miscompares++;
        $display("FAIL idle_quiet cycle %0d: outputs=%h required 0", c,
                 {req_ready, fifo_wr_en, fifo_w_data, grant_id, busy, burst_trunc, err_sticky});
      end
      tick();
    end
  endtask

  task automatic test_single();
    logic [7:0] beats [3];
    beats[0] = 8'hA1; beats[1] = 8'hA2; beats[2] = 8'hA3;
    do_reset();
    req_valid = 4'b0100;
    req_data[2*W +: W] = beats[0];
    @(negedge wr_clk);
    vectors++;
    if (busy !== 1'b0 || fifo_wr_en !== 1'b0) begin
      miscompares++;
      $display("FAIL single_arb_cycle: busy=%b wr_en=%b required 0 0", busy, fifo_wr_en);
    end
    for (int b = 0; b < 3; b++) begin
      tick();
      req_data[2*W +: W] = beats[b];
      req_last[2] = (b == 2);
      @(negedge wr_clk);
      vectors++;
      if ({busy, grant_id, req_ready, fifo_wr_en, fifo_w_data} !== {1'b1, 2'd2, 4'b0100, 1'b1, beats[b]})
      begin
        miscompares++;
        $display("FAIL single_beat%0d: busy=%b grant=%0d ready=%b wr_en=%b data=%h required 1 2 0100 1 %h",
                 b, busy, grant_id, req_ready, fifo_wr_en, fifo_w_data, beats[b]);
      end
    end
    tick();
    clear_inputs();
    @(negedge wr_clk);
    vectors++;
    if (busy !== 1'b0 || burst_trunc !== 1'b0) begin
      miscompares++;
      $display("FAIL single_end: busy=%b trunc=%b required 0 0", busy, burst_trunc);
    end
    // rr_ptr must now be 3: with 1 and 3 both asking, 3 wins.
    tick();
    req_valid = 4'b1010;
    req_last  = 4'b1010;
    tick();
    @(negedge wr_clk);
    vectors++;
    if (busy !== 1'b1 || grant_id !== 2'd3) begin
      miscompares++;
      $display("FAIL single_rr_ptr: busy=%b grant=%0d required 1 3", busy, grant_id);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_all_four();
    int ref_order [8];
    do_reset();
    for (int r = 0; r < N; r++) begin
      push_burst(r, 2, 1'b1);
      push_burst(r, 2, 1'b1);
    end
    for (int k = 0; k < 8; k++) ref_order[k] = k % 4;
    model_expect();
    run_engine(0, 0);
    vectors++;
    if (timed_out || got_grant.size() != 8 || got_data.size() != 16) begin
      miscompares++;
      $display("FAIL all4_counts: timeout=%b grants=%0d beats=%0d required 0 8 16",
               timed_out, got_grant.size(), got_data.size());
    end
    for (int k = 0; k < 8 && k < got_grant.size(); k++) begin
      vectors++;
      if (got_grant[k] != ref_order[k] || got_grant[k] != exp_grant[k]) begin
        miscompares++;
        $display("FAIL all4_grant%0d: got %0d required %0d", k, got_grant[k], ref_order[k]);
      end
    end
    for (int k = 0; k < 16 && k < got_data.size(); k++) begin
      vectors++;
      if (got_data[k] !== exp_data[k]) begin
        miscompares++;
        $display("FAIL all4_data%0d: got %h required %h", k, got_data[k], exp_data[k]);
      end
    end
    // Two beats plus one IDLE bubble per grant: writes span cycles 1..23.
    vectors++;
    if (first_wr != 1 || last_wr != 23 || proto_bad != 0 || trunc_cnt != 0) begin
      miscompares++;
      $display("FAIL all4_timing: first=%0d last=%0d proto=%0d trunc=%0d required 1 23 0 0",
               first_wr, last_wr, proto_bad, trunc_cnt);
    end
  endtask

  task automatic test_max_burst();
    int ref_order [4];
    ref_order[0] = 0; ref_order[1] = 1; ref_order[2] = 3; ref_order[3] = 1;
    do_reset();
    push_burst(0, 8, 1'b1);   // exactly MB beats with last: not a truncation
    push_burst(1, 10, 1'b0);  // no last: truncated at 8, then 2 more under a new grant
    push_burst(3, 1, 1'b1);
    model_expect();
    run_engine(0, 0);
    vectors++;
    if (timed_out || got_grant.size() != 4 || got_data.size() != exp_data.size()) begin
      miscompares++;
      $display("FAIL max_counts: timeout=%b grants=%0d beats=%0d required 0 4 %0d",
               timed_out, got_grant.size(), got_data.size(), exp_data.size());
    end
    for (int k = 0; k < 4 && k < got_grant.size(); k++) begin
      vectors++;
      if (got_grant[k] != ref_order[k] || got_grant[k] != exp_grant[k]) begin
        miscompares++;
        $display("FAIL max_grant%0d: got %0d required %0d", k, got_grant[k], ref_order[k]);
      end
    end
    for (int k = 0; k < exp_data.size() && k < got_data.size(); k++) begin
      vectors++;
      if (got_data[k] !== exp_data[k]) begin
        miscompares++;
        $display("FAIL max_data%0d: got %h required %h", k, got_data[k], exp_data[k]);
      end
    end
    vectors++;
    if (trunc_cnt != 1 || exp_trunc != 1 || proto_bad != 0) begin
      miscompares++;
      $display("FAIL max_trunc: pulses=%0d proto=%0d required 1 0", trunc_cnt, proto_bad);
    end
  endtask

  task automatic test_full_stall();
    do_reset();
    push_burst(0, 6, 1'b1);
    model_expect();
    run_engine(2, 3);
    vectors++;
    if (timed_out || got_data.size() != 6) begin
      miscompares++;
      $display("FAIL stall_count: timeout=%b beats=%0d required 0 6", timed_out, got_data.size());
    end
    for (int k = 0; k < 6 && k < got_data.size(); k++) begin
      vectors++;
      if (got_data[k] !== exp_data[k]) begin
        miscompares++;
        $display("FAIL stall_data%0d: got %h required %h", k, got_data[k], exp_data[k]);
      end
    end
    // Beats at 1,2, full over 3..7, resume at 8 and finish at 11.
    vectors++;
    if (stall_bad != 0 || proto_bad != 0 || first_wr != 1 || last_wr != 11) begin
      miscompares++;
      $display("FAIL stall_timing: stall_bad=%0d proto=%0d first=%0d last=%0d required 0 0 1 11",
               stall_bad, proto_bad, first_wr, last_wr);
    end
  endtask

  task automatic test_random(input int iter);
    int nb;
    do_reset();
    for (int r = 0; r < N; r++) begin
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) push_burst(r, $urandom_range(1, 12), 1'b1);
    end
    model_expect();
    run_engine(1, 0);
    vectors++;
    if (timed_out || got_grant.size() != exp_grant.size() || got_data.size() != exp_data.size()
        || trunc_cnt != exp_trunc || stall_bad != 0 || proto_bad != 0) begin
      miscompares++;
      $display("FAIL rand%0d_summary: to=%b grants=%0d/%0d beats=%0d/%0d trunc=%0d/%0d stall=%0d proto=%0d",
               iter, timed_out, got_grant.size(), exp_grant.size(), got_data.size(),
               exp_data.size(), trunc_cnt, exp_trunc, stall_bad, proto_bad);
    end
    for (int k = 0; k < exp_grant.size() && k < got_grant.size(); k++) begin
      vectors++;
      if (got_grant[k] != exp_grant[k]) begin
        miscompares++;
        $display("FAIL rand%0d_grant%0d: got %0d required %0d", iter, k, got_grant[k], exp_grant[k]);
      end
    end
    for (int k = 0; k < exp_data.size() && k < got_data.size(); k++) begin
      vectors++;
      if (got_data[k] !== exp_data[k]) begin
        miscompares++;
        $display("FAIL rand%0d_data%0d: got %h required %h", iter, k, got_data[k], exp_data[k]);
      end
    end
  endtask

  task automatic test_reset_mid_err();
    do_reset();
    req_valid = 4'b0100; req_last = 4'b0100; req_data[2*W +: W] = 8'h5A;
    tick();
    tick();
    clear_inputs();
    tick();                       // requester 2 done, rr_ptr now 3
    fifo_wr_err = 1'b1;
    req_valid = 4'b0010; req_data[1*W +: W] = 8'h10;
    tick();
    fifo_wr_err = 1'b0;
    @(negedge wr_clk);
    vectors++;
    if (err_sticky !== 1'b1 || busy !== 1'b1 || grant_id !== 2'd1) begin
      miscompares++;
      $display("FAIL mid_pre: err=%b busy=%b grant=%0d required 1 1 1", err_sticky, busy, grant_id);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 4'b1010; req_last = 4'b1010;
    req_data[1*W +: W] = 8'h11; req_data[3*W +: W] = 8'h33;
    @(negedge wr_clk);
    vectors++;
    if ({busy, err_sticky, burst_trunc, fifo_wr_en, req_ready} !== '0) begin
      miscompares++;
      $display("FAIL mid_after_rst: busy=%b err=%b trunc=%b wr_en=%b ready=%b required all 0",
               busy, err_sticky, burst_trunc, fifo_wr_en, req_ready);
    end
    tick();
    @(negedge wr_clk);
    vectors++;
    if (busy !== 1'b1 || grant_id !== 2'd1 || fifo_w_data !== 8'h11) begin
      miscompares++;
      $display("FAIL mid_rr_reset: busy=%b grant=%0d data=%h required 1 1 11",
               busy, grant_id, fifo_w_data);
    end
    tick();
    clear_inputs();
    fifo_wr_err = 1'b1;
    tick();
    fifo_wr_err = 1'b0;
    @(negedge wr_clk);
    vectors++;
    if (err_sticky !== 1'b1) begin
      miscompares++;
      $display("FAIL err_set: got %b required 1", err_sticky);
    end
    tick();
    @(negedge wr_clk);
    vectors++;
    if (err_sticky !== 1'b1) begin
      miscompares++;
      $display("FAIL err_hold: got %b required 1", err_sticky);
    end
    fifo_wr_err = 1'b1; err_clr = 1'b1;
    tick();
    fifo_wr_err = 1'b0; err_clr = 1'b0;
    @(negedge wr_clk);
    vectors++;
    if (err_sticky !== 1'b1) begin
      miscompares++;
      $display("FAIL err_set_wins: got %b required 1", err_sticky);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge wr_clk);
    vectors++;
    if (err_sticky !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clear: got %b required 0", err_sticky);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_all_four();
    test_max_burst();
    test_full_stall();
    for (int it = 0; it < 6; it++) test_random(it);
    test_reset_mid_err();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
